// File: rtl/gf16_pkg.sv
// GF(2^4) constants and helpers (x^4+x+1, alpha = 2) shared by the BCH syndrome
// generator and the error-location decoder.
package gf16_pkg;

  localparam int NUM_LOC = 3;
  localparam int NUM_SYN = 6;

  localparam logic [3:0] GF_ZERO_LOG = 4'd15;
  localparam logic [3:0] NO_ERR_LOC  = 4'd15;

  localparam logic [3:0] ALPHA_POW [0:14] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  localparam logic [3:0] LOG_OF [1:15] = '{
    4'd0, 4'd1, 4'd4, 4'd2, 4'd8, 4'd5, 4'd10, 4'd3,
    4'd14, 4'd9, 4'd7, 4'd6, 4'd13, 4'd11, 4'd12
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OUT
  } state_e;

  // (j*loc) mod 15 via end-around folding, since 16 == 1 (mod 15).
  function automatic logic [3:0] exp_mod15(input logic [2:0] j, input logic [3:0] loc);
    logic [6:0] p;
    logic [4:0] s1;
    logic [3:0] s2;
    p  = 7'(j) * 7'(loc);
    s1 = 5'(p[3:0]) + 5'(p[6:4]);
    s2 = s1[3:0] + {3'b000, s1[4]};
    return (s2 == 4'd15) ? 4'd0 : s2;
  endfunction

endpackage

// File: rtl/gf16_vec2log.sv
// Combinational GF(2^4) vector-to-log conversion; the zero element maps to 15.
module gf16_vec2log
  import gf16_pkg::*;
(
  input  logic [3:0] i_vec,
  output logic [3:0] o_log
);

  always_comb begin
    o_log = GF_ZERO_LOG;
    if (i_vec != 4'd0) o_log = LOG_OF[i_vec];
  end

endmodule

// File: rtl/bch_syndrome_gen.sv
// BCH(15,k) syndrome generator: folds up to three error locations into S1..S6
// and streams them out in log form, one syndrome per cycle.
module bch_syndrome_gen
  import gf16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_location,
  output logic       out_valid,
  output logic [3:0] out_syndrome
);

  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_cnt;
  logic [3:0] r_acc     [0:NUM_SYN-1];
  logic [3:0] w_contrib [0:NUM_SYN-1];
  logic [3:0] w_sel_acc;
  logic [3:0] w_sel_log;
  logic       r_out_valid;
  logic [3:0] r_out_syn;

  // r_acc[j] / w_contrib[j] belong to syndrome S(j+1).
  always_comb begin
    for (int j = 0; j < NUM_SYN; j++) begin
      w_contrib[j] = 4'd0;
      if (in_location != NO_ERR_LOC)
        w_contrib[j] = ALPHA_POW[exp_mod15(3'(j + 1), in_location)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_LOAD;
      ST_LOAD: if (!in_valid || r_cnt == 3'(NUM_LOC - 1)) w_next = ST_OUT;
      ST_OUT:  if (r_cnt == 3'(NUM_SYN - 1)) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // r_cnt counts accepted beats in LOAD and emitted syndromes in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      for (int j = 0; j < NUM_SYN; j++) r_acc[j] <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= in_valid ? 3'd1 : 3'd0;
          for (int j = 0; j < NUM_SYN; j++)
            r_acc[j] <= in_valid ? w_contrib[j] : 4'd0;
        end
        ST_LOAD: begin
          r_cnt <= (w_next == ST_OUT) ? 3'd0 : r_cnt + 3'd1;
          if (in_valid)
            for (int j = 0; j < NUM_SYN; j++)
              r_acc[j] <= r_acc[j] ^ w_contrib[j];
        end
        ST_OUT:  r_cnt <= (w_next == ST_IDLE) ? 3'd0 : r_cnt + 3'd1;
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  always_comb begin
    w_sel_acc = 4'd0;
    case (r_cnt)
      3'd0:    w_sel_acc = r_acc[0];
      3'd1:    w_sel_acc = r_acc[1];
      3'd2:    w_sel_acc = r_acc[2];
      3'd3:    w_sel_acc = r_acc[3];
      3'd4:    w_sel_acc = r_acc[4];
      3'd5:    w_sel_acc = r_acc[5];
      default: w_sel_acc = 4'd0;
    endcase
  end

  gf16_vec2log u_vec2log (
    .i_vec (w_sel_acc),
    .o_log (w_sel_log)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_syn   <= 4'd0;
    end else begin
      r_out_valid <= (r_state == ST_OUT);
      r_out_syn   <= (r_state == ST_OUT) ? w_sel_log : 4'd0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_syndrome = r_out_syn;

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Directed + randomized scoreboard bench for bch_syndrome_gen.
module tb_bch_syndrome_gen;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_location;
  logic       out_valid;
  logic [3:0] out_syndrome;

  int         total = 0;
  int         bad   = 0;
  int         run   = 0;
  logic [3:0] q [$];

  bch_syndrome_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_location  (in_location),
    .out_valid    (out_valid),
    .out_syndrome (out_syndrome)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: field built by shift-and-reduce, log found by search.
  function automatic logic [3:0] mulx(input logic [3:0] v);
    return {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [3:0] apow(input int e);
    logic [3:0] v;
    v = 4'd1;
    for (int i = 0; i < e; i++) v = mulx(v);
    return v;
  endfunction

  function automatic logic [3:0] glog(input logic [3:0] v);
    if (v == 4'd0) return 4'd15;
    for (int e = 0; e < 15; e++) if (apow(e) == v) return 4'(e);
    return 4'd15;
  endfunction

  function automatic logic [23:0] model(input int n, input logic [11:0] locs);
    logic [23:0] res;
    logic [3:0]  acc;
    logic [3:0]  l;
    res = 24'd0;
    for (int j = 1; j <= 6; j++) begin
      acc = 4'd0;
      for (int i = 0; i < n; i++) begin
        l = locs[11-4*i -: 4];
        if (l != 4'd15) acc = acc ^ apow((j * int'(l)) % 15);
      end
      res[23-4*(j-1) -: 4] = glog(acc);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (out_valid) begin
      run++;
      if (q.size() == 0) begin
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_beat got=%0h exp=none", out_syndrome);
        end
      end else begin
        chk("syndrome", 32'(out_syndrome), 32'(q.pop_front()));
      end
    end else begin
      if (run != 0) begin
        chk("valid_run_len", run, 6);
        run = 0;
      end
      chk("idle_zero", 32'(out_syndrome), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns 1ns after the edge that presents beat 6 (back-to-back safe).
  task automatic send_frame(input int n, input logic [11:0] locs, input logic [23:0] exp,
                            input bit extra);
    for (int j = 0; j < 6; j++) q.push_back(exp[23-4*j -: 4]);
    for (int i = 0; i < n; i++) begin
      in_valid    = 1'b1;
      in_location = locs[11-4*i -: 4];
      @(posedge clk); #1;
    end
    if (n < 3) begin
      in_valid    = 1'b0;
      in_location = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end else if (extra) begin
      in_valid    = 1'b1;
      in_location = 4'd7;
    end else begin
      in_valid = 1'b0;
    end
    chk("no_early_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency", 32'(out_valid), 1);
    repeat (5) begin @(posedge clk); #1; end
    chk("beat6_valid", 32'(out_valid), 1);
  endtask

  initial begin
    logic [11:0] locs;
    int          n;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_location = 4'd0;
    idle(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_syn", 32'(out_syndrome), 0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_valid", 32'(out_valid), 0);

    send_frame(3, 12'hFFF, 24'hFFFFFF, 1'b0);
    idle(2);
    send_frame(3, 12'h1FF, 24'h123456, 1'b0);
    idle(2);
    send_frame(3, 12'h5FF, 24'h5A05A0, 1'b0);
    idle(2);
    send_frame(3, 12'h12F, 24'h5A2504, 1'b0);
    idle(2);
    send_frame(3, 12'h33F, 24'hFFFFFF, 1'b0);
    idle(2);

    // Early deassert, then a second frame with zero gap.
    send_frame(1, 12'h0FF, 24'h000000, 1'b0);
    send_frame(1, 12'h1FF, 24'h123456, 1'b0);
    idle(2);

    // Fourth consecutive beat lands in OUT and must be ignored.
    send_frame(3, 12'h5FF, 24'h5A05A0, 1'b1);
    idle(3);

    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(1, 3);
      locs = 12'($urandom);
      send_frame(n, locs, model(n, locs), 1'b0);
      if (r % 2 == 0) idle(2);
    end
    idle(3);

    // Reset during OUT beat 3.
    q.push_back(4'd5);
    q.push_back(4'd10);
    for (int i = 0; i < 3; i++) begin
      in_valid    = 1'b1;
      in_location = (i == 0) ? 4'd5 : 4'd15;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_syn", 32'(out_syndrome), 0);
    chk("abort_popped", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    idle(10);
    send_frame(1, 12'h1FF, 24'h123456, 1'b0);
    idle(10);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
